// File: rtl/alu_mul_seq_if.sv
// Bundle between the shift-and-add multiply sequencer and its surroundings:
// the request/result handshake plus the borrowed alu32 operand/result bus.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_f;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_overflow;

    // master is the environment: the request source together with the attached ALU
    modport master (
        output start, op_a, op_b, alu_y, alu_zero, alu_overflow,
        input  busy, done, product, zero, alu_a, alu_b, alu_f
    );

    modport slave (
        input  start, op_a, op_b, alu_y, alu_zero, alu_overflow,
        output busy, done, product, zero, alu_a, alu_b, alu_f
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH multiply (low WIDTH bits) built from repeated ALU ADDs,
// followed by one ALU SUB pass against zero to obtain the zero flag.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);
    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [2:0]         F_ADD    = 3'b010;
    localparam logic [2:0]         F_SUB    = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLAG
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] product_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             add_en;
    logic [WIDTH-1:0] addend;
    logic             unused_overflow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            zero_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mcand_reg  <= bus.op_a;
                        mplier_reg <= bus.op_b;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // one multiplier bit per cycle, no early exit on a zero multiplier
                    acc_reg    <= bus.alu_y;
                    mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= FLAG;
                    end
                end
                FLAG: begin
                    product_reg <= bus.alu_y;
                    zero_reg    <= bus.alu_zero;
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // addend is the shifted multiplicand gated by the current multiplier bit
    assign add_en = (state_reg == RUN) && mplier_reg[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & add_en;
        end
    endgenerate

    assign bus.alu_a = (state_reg == IDLE) ? '0 : acc_reg;
    assign bus.alu_b = addend;
    assign bus.alu_f = (state_reg == FLAG) ? F_SUB : F_ADD;

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;
    assign bus.zero    = zero_reg;

    assign unused_overflow = bus.alu_overflow;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural alu32 attached; results are
// checked by a scoreboard monitor that pops expectations whenever done pulses.
module tb_alu_mul_seq;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [W-1:0] p;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    alu_mul_seq_if #(.WIDTH(W)) bus ();

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural alu32
    logic [W-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_f)
            3'b000:  alu_res = bus.alu_a & bus.alu_b;
            3'b001:  alu_res = bus.alu_a | bus.alu_b;
            3'b010:  alu_res = bus.alu_a + bus.alu_b;
            3'b110:  alu_res = bus.alu_a - bus.alu_b;
            3'b111:  alu_res = {{(W-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_y        = alu_res;
    assign bus.alu_zero     = (alu_res == '0);
    assign bus.alu_overflow = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_res[W-1] != bus.alu_a[W-1]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("txn: product=%08h zero=%0b cycle=%0d (expected %08h/%0b/%0d)",
                         bus.product, bus.zero, cyc, e.p, e.z, e.cyc);
                chk("product", bus.product, e.p);
                chk("zero", bus.zero, e.z);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    // called at a negedge with the DUT idle; returns just after the accepting edge
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_p, input logic exp_z, input bit keep_start);
        exp_t e;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.p   = exp_p;
        e.z   = exp_z;
        e.cyc = cyc + W + 1;
        exp_q.push_back(e);
        if (!keep_start) bus.start = 1'b0;
    endtask

    // ALU bus checks through RUN (k < W) and FLAG (k == W)
    task automatic watch_run(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eb;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (k < W) begin
                eb = b[k] ? (a << k) : '0;
                chk("run_f", bus.alu_f, 3'b010);
                chk("run_b", bus.alu_b, eb);
                chk("run_busy", bus.busy, 1'b1);
            end else begin
                chk("flag_f", bus.alu_f, 3'b110);
                chk("flag_b", bus.alu_b, '0);
                chk("flag_busy", bus.busy, 1'b1);
            end
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_p, input logic exp_z);
        accept(a, b, exp_p, exp_z, 1'b0);
        watch_run(a, b);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_product", bus.product, '0);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_alu_f", bus.alu_f, 3'b010);
        chk("rst_alu_a", bus.alu_a, '0);
        chk("rst_alu_b", bus.alu_b, '0);

        run_one(32'd3, 32'd5, 32'd15, 1'b0);
        run_one(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // start held through busy with operands changing mid-run, then re-accepted in the done cycle
        accept(32'd150000, 32'd0, 32'd0, 1'b1, 1'b1);
        fork
            watch_run(32'd150000, 32'd0);
            begin
                repeat (10) @(negedge clk);
                bus.op_a = 32'd7;
                bus.op_b = 32'd9;
            end
        join
        @(negedge clk);
        accept(32'd7, 32'd9, 32'd63, 1'b0, 1'b0);
        watch_run(32'd7, 32'd9);
        repeat (2) @(negedge clk);

        // reset in the middle of RUN aborts without a done
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_product", bus.product, '0);
        chk("abort_zero", bus.zero, 1'b0);
        repeat (40) @(negedge clk);
        chk("abort_product_held", bus.product, '0);

        run_one(32'd3, 32'd5, 32'd15, 1'b0);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
